// File: rtl/cherry_isa_pkg.sv
// cherry_isa_pkg: instruction slot widths and dispatcher state encoding
package cherry_isa_pkg;
  localparam int DMA_W = 22;
  localparam int ARITH_W = 1;
  localparam int CACHE_W = 17;
  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH} dispatch_state_t;
endpackage

// File: rtl/dispatch_lane_buffer.sv
// dispatch_lane_buffer: four W-bit staging slots for one instruction queue lane
module dispatch_lane_buffer #(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           we,
  input  logic [1:0]     idx,
  input  logic [W-1:0]   din,
  input  logic           clr,
  output logic [4*W-1:0] q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else if (clr) q <= '0;
    else if (we) q[idx*W +: W] <= din;
endmodule

// File: rtl/instruction_dispatch.sv
// instruction_dispatch: gathers decoded bundles into lockstep bursts for the DMA/arith/cache queues
module instruction_dispatch
  import cherry_isa_pkg::*;
#(
  parameter int BURST = 4,
  parameter int FLUSH_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DMA_W-1:0]     in_dma,
  input  logic [ARITH_W-1:0]   in_arith,
  input  logic [CACHE_W-1:0]   in_cache,
  input  logic                 in_last,
  output logic                 q_we,
  output logic [1:0]           q_we_count,
  output logic [4*DMA_W-1:0]   dma_dat_w,
  output logic [4*ARITH_W-1:0] arith_dat_w,
  output logic [4*CACHE_W-1:0] cache_dat_w,
  input  logic                 dma_full_soon,
  input  logic                 arith_full_soon,
  input  logic                 cache_full_soon,
  output logic                 program_done
);
  dispatch_state_t state, state_nx;
  logic [2:0] count;
  logic [7:0] timer, timer_nx;
  logic last_pend, accept, fs_any, go_flush;
  assign in_ready = (state == IDLE || state == COLLECT) && count < 3'(BURST);
  assign accept = in_valid & in_ready;
  assign fs_any = dma_full_soon | arith_full_soon | cache_full_soon;
  assign q_we = state == FLUSH && !fs_any;
  assign q_we_count = 2'(count - 3'd1);
  assign program_done = q_we & last_pend;
  // the flush decision uses the post-edge count/timer so FLUSH starts right after the triggering edge
  always_comb begin
    timer_nx = accept ? 8'd0 : timer + 8'd1;
    go_flush = (accept && (in_last || count == 3'(BURST - 1))) ||
               (state == COLLECT && !accept && timer_nx == 8'(FLUSH_TIMEOUT));
    state_nx = state == FLUSH ? (fs_any ? FLUSH : IDLE) :
               go_flush       ? FLUSH :
               accept         ? COLLECT : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count <= '0;
      timer <= '0;
      last_pend <= 1'b0;
    end else begin
      count <= q_we ? 3'd0 : accept ? count + 3'd1 : count;
      timer <= state == COLLECT ? timer_nx : 8'd0;
      last_pend <= q_we ? 1'b0 : (accept && in_last) ? 1'b1 : last_pend;
    end
  dispatch_lane_buffer #(.W(DMA_W)) u_dma (
    .clk(clk), .reset(reset), .we(accept), .idx(count[1:0]), .din(in_dma), .clr(q_we), .q(dma_dat_w)
  );
  dispatch_lane_buffer #(.W(ARITH_W)) u_arith (
    .clk(clk), .reset(reset), .we(accept), .idx(count[1:0]), .din(in_arith), .clr(q_we), .q(arith_dat_w)
  );
  dispatch_lane_buffer #(.W(CACHE_W)) u_cache (
    .clk(clk), .reset(reset), .we(accept), .idx(count[1:0]), .din(in_cache), .clr(q_we), .q(cache_dat_w)
  );
endmodule

// File: tb/tb_instruction_dispatch.sv
// tb_instruction_dispatch: directed and randomized checks against a queue-based burst model
module tb_instruction_dispatch;
  import cherry_isa_pkg::*;
  localparam int FT = 8;
  logic clk = 0, reset = 0, in_valid = 0, in_last = 0;
  logic dfs = 0, afs = 0, cfs = 0;
  logic [DMA_W-1:0] in_dma = '0;
  logic [ARITH_W-1:0] in_arith = '0;
  logic [CACHE_W-1:0] in_cache = '0;
  logic in_ready, q_we, program_done;
  logic [1:0] q_we_count;
  logic [4*DMA_W-1:0] dma_dat_w, snap;
  logic [4*ARITH_W-1:0] arith_dat_w;
  logic [4*CACHE_W-1:0] cache_dat_w;
  typedef struct {
    logic [DMA_W-1:0] d;
    logic [ARITH_W-1:0] a;
    logic [CACHE_W-1:0] c;
    logic l;
  } bundle_t;
  bundle_t pend[$];
  int errors = 0, checks = 0, cycle = 0;
  int we_cycle = 0, acc_cycle = 0, we_n = 0, n_acc = 0, n_wr = 0, a0;
  logic we_seen = 0, pd_seen = 0, last_acc = 0;

  instruction_dispatch #(.BURST(4), .FLUSH_TIMEOUT(FT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_dma(in_dma), .in_arith(in_arith), .in_cache(in_cache), .in_last(in_last),
    .q_we(q_we), .q_we_count(q_we_count), .dma_dat_w(dma_dat_w),
    .arith_dat_w(arith_dat_w), .cache_dat_w(cache_dat_w),
    .dma_full_soon(dfs), .arith_full_soon(afs), .cache_full_soon(cfs),
    .program_done(program_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rand_bundle(input logic last);
    in_valid = 1;
    in_dma = DMA_W'($urandom);
    in_arith = ARITH_W'($urandom);
    in_cache = CACHE_W'($urandom);
    in_last = last;
  endtask

  // one clock: score outputs at negedge, then return 1 time unit after the next posedge
  task automatic cyc();
    int n;
    bundle_t e;
    @(negedge clk);
    if (q_we) begin
      n = int'(q_we_count) + 1;
      we_seen = 1;
      we_cycle = cycle;
      we_n = n;
      pd_seen = program_done;
      n_wr += n;
      chk("fs_low", {dfs, afs, cfs}, 0);
      chk("we_count", n, pend.size());
      for (int i = 0; i < 4; i++) begin
        if (i < n && i < pend.size()) e = pend[i];
        else e = '{d: '0, a: '0, c: '0, l: 1'b0};
        chk("dma_slot", dma_dat_w[i*DMA_W +: DMA_W], e.d);
        chk("arith_slot", arith_dat_w[i*ARITH_W +: ARITH_W], e.a);
        chk("cache_slot", cache_dat_w[i*CACHE_W +: CACHE_W], e.c);
      end
      chk("done", program_done, pend.size() > 0 ? pend[pend.size()-1].l : 1'b0);
      pend.delete();
    end else chk("no_done", program_done, 0);
    if (last_acc || pend.size() == 4) chk("ready_low", in_ready, 0);
    last_acc = 0;
    if (in_valid && in_ready) begin
      pend.push_back('{d: in_dma, a: in_arith, c: in_cache, l: in_last});
      n_acc++;
      acc_cycle = cycle;
      last_acc = in_last;
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_we", q_we, 0);
    chk("rst_dma", dma_dat_w, 0);
    chk("rst_arith", arith_dat_w, 0);
    chk("rst_cache", cache_dat_w, 0);
    chk("rst_done", program_done, 0);
    reset = 1;
    cyc();
    // T1: four back-to-back bundles
    for (int k = 0; k < 4; k++) begin
      rand_bundle(0);
      chk("t1_ready", in_ready, 1);
      cyc();
    end
    in_valid = 0;
    we_seen = 0;
    chk("t1_ready_flush", in_ready, 0);
    chk("t1_we_now", q_we, 1);
    cyc();
    chk("t1_seen", we_seen, 1);
    chk("t1_n", we_n, 4);
    chk("t1_ready_back", in_ready, 1);
    // T2: two bundles ending with in_last
    in_valid = 1; in_dma = 22'h3C0000; in_arith = 0; in_cache = 0; in_last = 0;
    cyc();
    in_dma = 0; in_arith = 1; in_cache = 17'h1_8000; in_last = 1;
    cyc();
    in_valid = 0; in_last = 0; we_seen = 0;
    cyc();
    chk("t2_seen", we_seen, 1);
    chk("t2_n", we_n, 2);
    chk("t2_done", pd_seen, 1);
    // T3: partial burst flushed by timeout
    rand_bundle(0);
    cyc();
    cyc();
    in_valid = 0;
    we_seen = 0;
    a0 = acc_cycle;
    for (int k = 0; k < 40 && !we_seen; k++) cyc();
    chk("t3_seen", we_seen, 1);
    chk("t3_latency", we_cycle - a0, FT + 1);
    chk("t3_n", we_n, 2);
    // T4: cache back-pressure holds a full burst
    cfs = 1;
    for (int k = 0; k < 4; k++) begin
      rand_bundle(0);
      cyc();
    end
    in_valid = 0;
    snap = dma_dat_w;
    we_seen = 0;
    for (int k = 0; k < 10; k++) begin
      chk("t4_stall", q_we, 0);
      chk("t4_stable", dma_dat_w, snap);
      cyc();
    end
    chk("t4_no_we", we_seen, 0);
    cfs = 0;
    cyc();
    chk("t4_seen", we_seen, 1);
    chk("t4_n", we_n, 4);
    // T5: reset with three bundles staged
    for (int k = 0; k < 3; k++) begin
      rand_bundle(0);
      cyc();
    end
    in_valid = 0;
    cyc();
    #2;
    reset = 0;
    n_acc -= pend.size();
    pend.delete();
    we_seen = 0;
    repeat (3) cyc();
    reset = 1;
    chk("t5_ready", in_ready, 1);
    chk("t5_we", q_we, 0);
    chk("t5_dma", dma_dat_w, 0);
    repeat (FT + 5) cyc();
    chk("t5_no_we", we_seen, 0);
    rand_bundle(1);
    cyc();
    in_valid = 0; in_last = 0; we_seen = 0;
    cyc();
    chk("t5_seen", we_seen, 1);
    chk("t5_n", we_n, 1);
    chk("t5_done", pd_seen, 1);
    // T6: random traffic and back-pressure
    for (int k = 0; k < 10000; k++) begin
      rand_bundle($urandom_range(0, 31) == 0);
      in_valid = $urandom_range(0, 9) < 6;
      dfs = $urandom_range(0, 7) == 0;
      afs = $urandom_range(0, 7) == 0;
      cfs = $urandom_range(0, 7) == 0;
      cyc();
    end
    in_valid = 0; in_last = 0; dfs = 0; afs = 0; cfs = 0;
    for (int k = 0; k < 40 && pend.size() > 0; k++) cyc();
    chk("t6_drained", pend.size(), 0);
    chk("t6_totals", n_wr, n_acc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
